ttt_host_link: RTL

Host-side initiator for the tick-tock-tokens chip pin interface. It takes word-level read/write commands over a valid/ready port and serializes them as byte frames onto the chip's `ui_in`/`uio_in` pins. It then waits for the chip's acknowledge on `uo_out[7]`, captures read data from `uio_out`, and returns one response per command. It sits in the FPGA test harness and in simulation benches, directly wired to `tt_um_jleugeri_ticktocktokens`.

---
 rtl/ttt_host_link.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ttt_host_link.sv
// Host-side initiator for the tick-tock-tokens pin interface: serializes word
// read/write commands into strobed byte frames and collects the chip's acknowledge/read data.
module ttt_host_link #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic [7:0]  drv_ui,
  output logic [7:0]  drv_uio,
  input  logic [7:0]  dut_uo,
  input  logic [7:0]  dut_uio
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DHI,
    S_DLO,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [6:0]  addr;
    logic [15:0] data;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          beat_q, beat_d;
  logic [7:0]    rd_hi_q, rd_hi_d;
  logic          rsp_valid_d;
  logic [15:0]   rsp_data_d;
  logic          rsp_error_d;
  logic [7:0]    drv_ui_d;
  logic [7:0]    drv_uio_d;
  logic          ack;
  logic          hold_last;
  logic          strobe_d;
  logic          last_d;
  logic          unused_uo;

  assign ack       = dut_uo[7];
  assign unused_uo = ^dut_uo[6:0];
  assign hold_last = (hold_q == HW'(HOLD_CYCLES - 1));
  assign cmd_ready = (state_q == S_IDLE);

  // Next-state, command latch, wait/beat tracking and registered-output next values
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hold_d      = hold_q;
    wait_d      = wait_q;
    beat_d      = beat_q;
    rd_hi_d     = rd_hi_q;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_error_d = rsp_error;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
          hold_d  = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (hold_last) begin
          hold_d = '0;
          if (cmd_q.write) begin
            state_d = S_DHI;
          end else begin
            wait_d  = '0;
            beat_d  = 1'b0;
            state_d = S_WAIT;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DHI: begin
        if (hold_last) begin
          hold_d  = '0;
          state_d = S_DLO;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DLO: begin
        if (hold_last) begin
          hold_d  = '0;
          wait_d  = '0;
          beat_d  = 1'b0;
          state_d = S_WAIT;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_WAIT: begin
        // Ack takes priority over an expiring timeout in the same cycle
        if (ack) begin
          if (cmd_q.write || beat_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b0;
            rsp_data_d  = cmd_q.write ? 16'h0000 : {rd_hi_q, dut_uio};
            beat_d      = 1'b0;
          end else begin
            rd_hi_d = dut_uio;
            beat_d  = 1'b1;
            wait_d  = '0;
          end
        end else if (wait_q >= CW'(ACK_TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_data_d  = 16'h0000;
          beat_d      = 1'b0;
        end else if (wait_q != CW'(ACK_TIMEOUT)) begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 16'h0000;
          rsp_error_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin values follow the state being entered so they line up with the hold window
    drv_ui_d = 8'h00;
    unique case (state_d)
      S_HDR:   drv_ui_d = {cmd_d.write, cmd_d.addr};
      S_DHI:   drv_ui_d = cmd_d.data[15:8];
      S_DLO:   drv_ui_d = cmd_d.data[7:0];
      default: drv_ui_d = 8'h00;
    endcase
    strobe_d  = ((state_d == S_HDR) || (state_d == S_DHI) || (state_d == S_DLO)) &&
                (hold_d == HW'(HOLD_CYCLES - 1));
    last_d    = strobe_d && ((state_d == S_DLO) || ((state_d == S_HDR) && !cmd_d.write));
    drv_uio_d = {6'b000000, last_d, strobe_d};
  end

  // State and registered outputs; reset abandons any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      hold_q    <= '0;
      wait_q    <= '0;
      beat_q    <= 1'b0;
      rd_hi_q   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_error <= 1'b0;
      drv_ui    <= 8'h00;
      drv_uio   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      beat_q    <= beat_d;
      rd_hi_q   <= rd_hi_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_error <= rsp_error_d;
      drv_ui    <= drv_ui_d;
      drv_uio   <= drv_uio_d;
    end
  end

endmodule
